// File: rtl/bank_reader.sv
// rtl/bank_reader.sv - read-side burst controller for one SRAM bank with a 2-entry output FIFO
module bank_reader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 8
) (
  input  logic              vsi_clk,
  input  logic              vsi_reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              vsi_outputChipSelect,
  output logic [ADDR_W-1:0] vsi_outputAddr,
  input  logic [DATA_W-1:0] vsi_outputData,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_inflight;
  logic [DATA_W-1:0] r_buf [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic              w_load;
  logic [2:0]        w_occupancy;
  logic [1:0]        w_count_next;

  // A word leaves when the head is offered and accepted; bank data lands the
  // cycle after its chip select, so the in-flight flag doubles as the push.
  assign w_pop        = m_valid & m_ready;
  assign w_push       = r_inflight;
  // Slots already committed (buffered + on the way) after this cycle's pop.
  assign w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

  assign vsi_outputChipSelect = w_issue;
  assign vsi_outputAddr       = r_addr;
  assign m_valid              = (r_count != 2'd0);
  assign m_data               = r_buf[r_rd_ptr];

  // State register.
  always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
    if (!vsi_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, read issue and status outputs.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_load       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            w_load       = 1'b1;
            w_next_state = S_ISSUE;
          end else begin
            w_next_state = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (w_occupancy < 3'd2) begin
          w_issue = 1'b1;
          if (r_remaining == LEN_W'(1)) begin
            w_next_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Leave as soon as the final word is being accepted this cycle.
        if (!r_inflight && (w_count_next == 2'd0)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Burst address and remaining-word bookkeeping; address wraps at the bank end.
  always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
    if (!vsi_reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_load) begin
        r_addr      <= start_addr;
        r_remaining <= length;
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
      end
    end
  end

  // Two-entry output FIFO; bank data is captured unconditionally when it arrives.
  always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
    if (!vsi_reset_n) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= vsi_outputData;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_next;
    end
  end

endmodule
